// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: request classes,
// ALU op codes, RV64I opcode/funct constants, range limits, field packers.
package instr_encoder_pkg;

    localparam int ALU_OP_WIDTH = 4;
    typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'd0;
    localparam alu_op_t ALU_SUB  = 4'd1;
    localparam alu_op_t ALU_SLL  = 4'd2;
    localparam alu_op_t ALU_SLT  = 4'd3;
    localparam alu_op_t ALU_SLTU = 4'd4;
    localparam alu_op_t ALU_XOR  = 4'd5;
    localparam alu_op_t ALU_SRL  = 4'd6;
    localparam alu_op_t ALU_SRA  = 4'd7;
    localparam alu_op_t ALU_OR   = 4'd8;
    localparam alu_op_t ALU_AND  = 4'd9;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_R32     = 4'd1,
        CLS_I_IMM   = 4'd2,
        CLS_I_IMM32 = 4'd3,
        CLS_LOAD    = 4'd4,
        CLS_STORE   = 4'd5,
        CLS_BRANCH  = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JALR    = 4'd8,
        CLS_LUI     = 4'd9,
        CLS_AUIPC   = 4'd10
    } enc_class_t;

    typedef enum logic {
        S_RUN,
        S_ERR
    } enc_state_t;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_OP    = 3'd1;
    localparam logic [2:0] ERR_RANGE = 3'd2;
    localparam logic [2:0] ERR_ALIGN = 3'd3;
    localparam logic [2:0] ERR_WIDTH = 3'd4;
    localparam logic [2:0] ERR_CLASS = 3'd5;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [5:0] SRAI_HI = 6'b010000;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam int IMM_I_MIN   = -2048;
    localparam int IMM_I_MAX   = 2047;
    localparam int IMM_B_MIN   = -4096;
    localparam int IMM_B_MAX   = 4094;
    localparam int IMM_J_MIN   = -1048576;
    localparam int IMM_J_MAX   = 1048574;
    localparam int SHAMT64_MAX = 63;
    localparam int SHAMT32_MAX = 31;

    function automatic logic [2:0] alu_f3(alu_op_t op);
        logic [2:0] f;
        case (op)
            ALU_SLL:  f = 3'b001;
            ALU_SLT:  f = 3'b010;
            ALU_SLTU: f = 3'b011;
            ALU_XOR:  f = 3'b100;
            ALU_SRL:  f = 3'b101;
            ALU_SRA:  f = 3'b101;
            ALU_OR:   f = 3'b110;
            ALU_AND:  f = 3'b111;
            default:  f = 3'b000;
        endcase
        return f;
    endfunction

    function automatic logic in_range(logic [31:0] v, int lo, int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2,
                                          logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd,
                                          logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2,
                                          logic [4:0] rs1, logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(logic [12:1] imm, logic [4:0] rs2,
                                          logic [4:0] rs1, logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_u(logic [31:12] imm, logic [4:0] rd,
                                          logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    function automatic logic [31:0] enc_j(logic [20:1] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Synchronous FIFO with flush; head word is readable combinationally.
// Pointers carry one extra wrap bit to separate full from empty.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && !full && rst_n && !flush;
    assign do_pop  = pop && !empty;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + (AW+1)'(1);
            if (do_pop)  rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// Validates abstract op requests, encodes RV64I words, streams them to imem.
// Define ENC_STATS_EN to add saturating write/error counters.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              req_class,
    input  logic [ALU_OP_WIDTH-1:0] req_alu_op,
    input  logic [2:0]              req_width,
    input  logic                    req_flag,
    input  logic [4:0]              req_rd,
    input  logic [4:0]              req_rs1,
    input  logic [4:0]              req_rs2,
    input  logic [31:0]             req_imm,
    output logic                    imem_we,
    input  logic                    imem_ready,
    output logic [ADDR_W-1:0]       imem_addr,
    output logic [31:0]             imem_wdata,
    output logic                    err_valid,
    output logic [2:0]              err_code,
    input  logic                    err_clear,
    input  logic                    restart
`ifdef ENC_STATS_EN
    ,
    output logic [15:0]             stat_words,
    output logic [7:0]              stat_errs
`endif
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    enc_state_t  state;
    logic        full;
    logic        empty;
    logic        accept;
    logic        push;
    logic        pop;
    logic [2:0]  code;
    logic [31:0] word;
    logic        known;
    logic        is_sh;
    logic        is_alt;
    logic        w_op;
    logic [2:0]  f3;
    logic [2:0]  bf3;
    logic [11:0] i_imm;

    assign req_ready = rst_n && !restart && (state == S_RUN) && !full;
    assign accept    = req_valid && req_ready;
    assign push      = accept && (code == ERR_NONE);
    assign imem_we   = (state == S_RUN) && !empty;
    assign pop       = imem_we && imem_ready;

    always_comb begin
        code   = ERR_NONE;
        word   = '0;
        bf3    = 3'b000;
        known  = req_alu_op <= ALU_AND;
        is_sh  = (req_alu_op == ALU_SLL) || (req_alu_op == ALU_SRL) ||
                 (req_alu_op == ALU_SRA);
        is_alt = (req_alu_op == ALU_SUB) || (req_alu_op == ALU_SRA);
        w_op   = (req_alu_op == ALU_ADD) || (req_alu_op == ALU_SUB) || is_sh;
        f3     = alu_f3(req_alu_op);
        // Shift immediates carry the SRA marker above the shamt field.
        i_imm  = is_sh ? {(req_alu_op == ALU_SRA) ? SRAI_HI : 6'b0, req_imm[5:0]}
                       : req_imm[11:0];
        case (req_class)
            CLS_R: begin
                if (!known) code = ERR_OP;
                word = enc_r(is_alt ? F7_ALT : F7_BASE, req_rs2, req_rs1,
                             f3, req_rd, OPC_OP);
            end
            CLS_R32: begin
                if (!w_op) code = ERR_OP;
                word = enc_r(is_alt ? F7_ALT : F7_BASE, req_rs2, req_rs1,
                             f3, req_rd, OPC_OP32);
            end
            CLS_I_IMM: begin
                if (!known || req_alu_op == ALU_SUB)
                    code = ERR_OP;
                else if (is_sh ? !in_range(req_imm, 0, SHAMT64_MAX)
                               : !in_range(req_imm, IMM_I_MIN, IMM_I_MAX))
                    code = ERR_RANGE;
                word = enc_i(i_imm, req_rs1, f3, req_rd, OPC_OPIMM);
            end
            CLS_I_IMM32: begin
                if (!w_op || req_alu_op == ALU_SUB)
                    code = ERR_OP;
                else if (is_sh ? !in_range(req_imm, 0, SHAMT32_MAX)
                               : !in_range(req_imm, IMM_I_MIN, IMM_I_MAX))
                    code = ERR_RANGE;
                word = enc_i(i_imm, req_rs1, f3, req_rd, OPC_OPIMM32);
            end
            CLS_LOAD: begin
                if (req_width > 3'd3 || (req_flag && req_width == 3'd3))
                    code = ERR_WIDTH;
                else if (!in_range(req_imm, IMM_I_MIN, IMM_I_MAX))
                    code = ERR_RANGE;
                word = enc_i(req_imm[11:0], req_rs1,
                             {req_flag, req_width[1:0]}, req_rd, OPC_LOAD);
            end
            CLS_STORE: begin
                if (req_width > 3'd3 || req_flag)
                    code = ERR_WIDTH;
                else if (!in_range(req_imm, IMM_I_MIN, IMM_I_MAX))
                    code = ERR_RANGE;
                word = enc_s(req_imm[11:0], req_rs2, req_rs1,
                             {1'b0, req_width[1:0]});
            end
            CLS_BRANCH: begin
                unique case (1'b1)
                    req_alu_op == ALU_SUB:  bf3 = {2'b00, req_flag};
                    req_alu_op == ALU_SLT:  bf3 = {2'b10, req_flag};
                    req_alu_op == ALU_SLTU: bf3 = {2'b11, req_flag};
                    default:                code = ERR_OP;
                endcase
                if (code == ERR_NONE) begin
                    if (!in_range(req_imm, IMM_B_MIN, IMM_B_MAX))
                        code = ERR_RANGE;
                    else if (req_imm[0])
                        code = ERR_ALIGN;
                end
                word = enc_b(req_imm[12:1], req_rs2, req_rs1, bf3);
            end
            CLS_JAL: begin
                if (!in_range(req_imm, IMM_J_MIN, IMM_J_MAX))
                    code = ERR_RANGE;
                else if (req_imm[0])
                    code = ERR_ALIGN;
                word = enc_j(req_imm[20:1], req_rd);
            end
            CLS_JALR: begin
                if (!in_range(req_imm, IMM_I_MIN, IMM_I_MAX))
                    code = ERR_RANGE;
                word = enc_i(req_imm[11:0], req_rs1, F3_JALR, req_rd, OPC_JALR);
            end
            CLS_LUI: begin
                if (req_imm[11:0] != 12'd0) code = ERR_ALIGN;
                word = enc_u(req_imm[31:12], req_rd, OPC_LUI);
            end
            CLS_AUIPC: begin
                if (req_imm[11:0] != 12'd0) code = ERR_ALIGN;
                word = enc_u(req_imm[31:12], req_rd, OPC_AUIPC);
            end
            default: code = ERR_CLASS;
        endcase
    end

    enc_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (restart),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .rdata (imem_wdata),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            state     <= S_RUN;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            imem_addr <= BASE;
        end else begin
            err_valid <= 1'b0;
            if (accept && code != ERR_NONE) begin
                state     <= S_ERR;
                err_valid <= 1'b1;
                err_code  <= code;
            end else if (state == S_ERR && err_clear) begin
                state <= S_RUN;
            end
            if (pop) imem_addr <= imem_addr + ADDR_W'(4);
        end
    end

`ifdef ENC_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            stat_words <= '0;
            stat_errs  <= '0;
        end else begin
            if (pop && stat_words != '1)
                stat_words <= stat_words + 16'd1;
            if (accept && code != ERR_NONE && stat_errs != '1)
                stat_errs <= stat_errs + 8'd1;
        end
    end
`endif

endmodule
